axi_rd_slice_s16: RTL
=====================

# axi_rd_slice_s16

Registered AXI4 read-path slice with an outstanding-burst limiter. It sits between the instruction-fetch blocker and the DRAM controller's read port. It fully registers the AR and R channels, one full-throughput skid buffer per channel, to break long timing paths. It caps the number of read bursts in flight at P_MAX_OUTST. Write channels do not pass through this block.

## Interface
- P_AXI_IDWIDTH, 5, width of ARID/RID
- P_MAX_OUTST, 4, maximum read bursts accepted but not yet completed (legal range 1..15)
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- axis_arid / axis_araddr / axis_arlen / axis_arsize / axis_arburst  in  P_AXI_IDWIDTH / 32 / 4 / 3 / 2  slave AR payload
- axis_arlock / axis_arcache / axis_arprot / axis_aruser  in  1 / 4 / 3 / 1  slave AR payload
- axis_arvalid  in  1 ; axis_arready  out  1  slave AR handshake
- axis_rid / axis_rdata / axis_rresp / axis_rlast / axis_ruser  out  P_AXI_IDWIDTH / 64 / 2 / 1 / 1  slave R payload
- axis_rvalid  out  1 ; axis_rready  in  1  slave R handshake
- axim_ar* (same set as axis_ar*)  out  master AR payload; axim_arvalid  out  1 ; axim_arready  in  1
- axim_rid / axim_rdata / axim_rresp / axim_rlast / axim_ruser  in  master R payload; axim_rvalid  in  1 ; axim_rready  out  1
- rd_outst  out  4  current outstanding-burst count
- rd_err  out  1  sticky protocol-error flag (R last with zero outstanding)

## Operation
- Each channel (AR downstream, R upstream) uses an identical skid buffer:
  - A main register (valid + payload) drives the output side.
  - A skid register (valid + payload) captures one beat arriving while the output is stalled.
- Skid buffer, input side:
  - in_ready = ~skid_valid, registered.
  - A beat accepted while main is empty, or while main is draining this cycle with skid empty, loads main.
  - Otherwise the beat loads skid.
- Skid buffer, output side:
  - When main drains and skid is valid, skid moves to main and skid_valid clears.
  - Order is preserved; no beat is ever dropped or duplicated.
- AR gating:
  - axis_arready = ar_in_ready & (rd_outst != P_MAX_OUTST).
  - Both terms are registers, so there is no combinational input-to-output path on any channel.
- Counter (slave side):
  - +1 on the AR handshake (axis_arvalid & axis_arready).
  - −1 on the last-beat R handshake (axis_rvalid & axis_rready & axis_rlast).
  - Both in the same cycle: count unchanged.
- Underflow: an R last-beat handshake with rd_outst==0 and no simultaneous AR handshake leaves the count at 0 and sets rd_err. rd_err clears only on reset.
- Payloads pass through unmodified, including ID, user and resp. No ID reordering.

## Timing
- Reset (areset high at a clock edge), effective next cycle:
  - All valids 0: axim_arvalid, axis_rvalid, both skid valids.
  - rd_outst = 0, rd_err = 0.
  - axis_arready = 0, axim_rready = 0 during the reset cycle; both become 1 the first cycle after areset deasserts.
- Reset mid-burst discards all buffered beats. The counter restarts at 0.
- Payload registers need no reset. Payload outputs are don't-care while their valid is 0.
- Latency: 1 cycle input-to-output per channel when the buffer is empty (handshake at edge N, output valid after edge N).
- Throughput: 1 beat/cycle per channel under continuous ready.
- A beat held in skid adds 1 cycle.
- Once asserted, axim_arvalid and axis_rvalid hold with stable payload until their handshake.
- Ready deassertion: in_ready drops the cycle after a beat lands in skid and rises the cycle after skid drains.
- Full limiter: axis_arready is 0 while rd_outst == P_MAX_OUTST. It returns to 1 the cycle after the decrementing rlast handshake.

## Test plan
- Single read: AR (id=3, addr=0x80000100, len=3) with all readies 1 -> axim_arvalid one cycle later with identical payload; 4 R beats returned -> axis_r* one cycle behind each; rlast on beat 4; rd_outst goes 0→1→0.
- Back-pressure: axis_rready held 0 while 4 beats stream in -> axim_rready drops after 2 beats buffered (main + skid); releasing rready delivers all 4 beats in order with no loss or duplication.
- Limiter: issue 5 AR (len=0) with no R returned, P_MAX_OUTST=4 -> 4 accepted, axis_arready=0 on 5th; one rlast handshake -> 5th accepted next cycle; rd_outst peaks at 4.
- Simultaneous events: AR handshake in the same cycle as an rlast handshake with rd_outst=2 -> rd_outst stays 2.
- Underflow: inject axim_rvalid with rlast=1 and rd_outst=0 -> rd_err=1 the next cycle, rd_outst stays 0, rd_err stays 1 until areset.
- Reset mid-burst: assert areset while 2 beats are buffered -> all valids 0 and rd_outst=0 the next cycle; readies 1 the cycle after areset deasserts.

Source files
------------

// File: rtl/axi_rd_slice_s16_if.sv
// AXI4 read-path bundle (AR + R channels) shared by both sides of the read slice.
// The master modport drives AR and accepts R; the slave modport is its mirror.
interface axi_rd_slice_s16_if #(
  parameter int P_AXI_IDWIDTH = 5
);
  logic [P_AXI_IDWIDTH-1:0] arid;
  logic [31:0]              araddr;
  logic [3:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arlock;
  logic [3:0]               arcache;
  logic [2:0]               arprot;
  logic                     aruser;
  logic                     arvalid;
  logic                     arready;

  logic [P_AXI_IDWIDTH-1:0] rid;
  logic [63:0]              rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     ruser;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_slice_s16.sv
// Registered AXI4 read slice: one full-throughput skid buffer on AR and on R,
// plus a limiter capping the number of read bursts in flight at P_MAX_OUTST.
module axi_rd_slice_s16_skid #(
  parameter int P_W = 8
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [P_W-1:0] i_data,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [P_W-1:0] o_data
);
  logic           r_main_v, r_skid_v, r_in_ready;
  logic [P_W-1:0] r_main_d, r_skid_d;
  logic           w_in_hs, w_out_hs;
  logic           w_main_v_nxt, w_skid_v_nxt;
  logic           w_load_main_in, w_load_main_skid, w_load_skid;

  assign w_in_hs  = i_valid & r_in_ready;
  assign w_out_hs = r_main_v & i_ready;
  assign o_ready  = r_in_ready;
  assign o_valid  = r_main_v;
  assign o_data   = r_main_d;

  // NOTE: every signal gets a default before the branches, so no latch is inferred.
  always_comb begin
    w_main_v_nxt     = r_main_v;
    w_skid_v_nxt     = r_skid_v;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (w_out_hs && r_skid_v) begin
      w_load_main_skid = 1'b1;
      w_skid_v_nxt     = 1'b0;
    end else if (w_in_hs && (!r_main_v || w_out_hs)) begin
      w_load_main_in = 1'b1;
      w_main_v_nxt   = 1'b1;
    end else if (w_in_hs) begin
      w_load_skid  = 1'b1;
      w_skid_v_nxt = 1'b1;
    end else if (w_out_hs) begin
      w_main_v_nxt = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_main_v   <= w_main_v_nxt;
      r_skid_v   <= w_skid_v_nxt;
      r_in_ready <= ~w_skid_v_nxt;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while their valid is set.
  always_ff @(posedge aclk) begin
    if (w_load_main_skid)    r_main_d <= r_skid_d;
    else if (w_load_main_in) r_main_d <= i_data;
    if (w_load_skid)         r_skid_d <= i_data;
  end
endmodule

module axi_rd_slice_s16 #(
  parameter int P_AXI_IDWIDTH = 5,
  parameter int P_MAX_OUTST   = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_rd_slice_s16_if.slave     axis,
  axi_rd_slice_s16_if.master    axim,
  output logic [3:0]            rd_outst,
  output logic                  rd_err
);
  localparam int         LP_AR_W = P_AXI_IDWIDTH + 50;
  localparam int         LP_R_W  = P_AXI_IDWIDTH + 68;
  localparam logic [3:0] LP_MAX  = 4'(P_MAX_OUTST);

  logic               w_ar_in_ready, w_not_full, w_ar_in_valid;
  logic               w_ar_hs, w_rlast_hs;
  logic [LP_AR_W-1:0] w_ar_in, w_ar_out;
  logic [LP_R_W-1:0]  w_r_in, w_r_out;
  logic [3:0]         r_outst;
  logic               r_err;

  // Both terms come straight from flops, so arready has no path from any input.
  assign w_not_full    = (r_outst != LP_MAX);
  assign axis.arready  = w_ar_in_ready & w_not_full;
  assign w_ar_in_valid = axis.arvalid & w_not_full;

  assign w_ar_in = {axis.arid, axis.araddr, axis.arlen, axis.arsize, axis.arburst,
                    axis.arlock, axis.arcache, axis.arprot, axis.aruser};
  assign {axim.arid, axim.araddr, axim.arlen, axim.arsize, axim.arburst,
          axim.arlock, axim.arcache, axim.arprot, axim.aruser} = w_ar_out;

  axi_rd_slice_s16_skid #(.P_W(LP_AR_W)) u_ar_skid (
    .aclk    (aclk),
    .areset  (areset),
    .i_valid (w_ar_in_valid),
    .o_ready (w_ar_in_ready),
    .i_data  (w_ar_in),
    .o_valid (axim.arvalid),
    .i_ready (axim.arready),
    .o_data  (w_ar_out)
  );

  assign w_r_in = {axim.rid, axim.rdata, axim.rresp, axim.rlast, axim.ruser};
  assign {axis.rid, axis.rdata, axis.rresp, axis.rlast, axis.ruser} = w_r_out;

  axi_rd_slice_s16_skid #(.P_W(LP_R_W)) u_r_skid (
    .aclk    (aclk),
    .areset  (areset),
    .i_valid (axim.rvalid),
    .o_ready (axim.rready),
    .i_data  (w_r_in),
    .o_valid (axis.rvalid),
    .i_ready (axis.rready),
    .o_data  (w_r_out)
  );

  assign w_ar_hs    = axis.arvalid & axis.arready;
  assign w_rlast_hs = axis.rvalid & axis.rready & axis.rlast;

  // A burst counts as outstanding from slave-side AR acceptance to slave-side rlast delivery.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_outst <= '0;
      r_err   <= 1'b0;
    end else if (w_ar_hs && !w_rlast_hs) begin
      r_outst <= r_outst + 4'd1;
    end else if (!w_ar_hs && w_rlast_hs) begin
      if (r_outst == 4'd0) r_err   <= 1'b1;
      else                 r_outst <= r_outst - 4'd1;
    end
  end

  assign rd_outst = r_outst;
  assign rd_err   = r_err;
endmodule
